// File: rtl/qgroup.sv
// qgroup: adds one outer eot level to a queue stream.
// Completed input sub-transactions are counted; every item of the last
// sub-transaction in each group of N carries new_eot. N is read from the
// cfg stream and is consumed once per group, at the group's final item.
// The datapath is zero-latency; the only registered state is the counter.
module qgroup #(
    parameter int TDIN    = 16,
    parameter int DIN_LVL = 1,
    parameter int CFG_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CFG_W-1:0]          cfg_data,

    input  logic                      din_valid,
    output logic                      din_ready,
    input  logic [DIN_LVL+TDIN-1:0]   din_data,

    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic [DIN_LVL+TDIN:0]     dout_data
);

    logic [CFG_W-1:0] cnt_q;
    logic [CFG_W-1:0] cnt_d;
    logic [CFG_W-1:0] n_eff;
    logic             last;
    logic             sub_eot;
    logic             din_xfer;

    // A flat stream has no eot bits, so every item closes its own sub-transaction.
    if (DIN_LVL > 0) begin : g_lvl
        assign sub_eot = &din_data[TDIN +: DIN_LVL];
    end else begin : g_flat
        assign sub_eot = 1'b1;
    end

    // Group size of zero behaves like one; n_eff is never zero so n_eff-1 cannot wrap.
    assign n_eff = (cfg_data == '0) ? CFG_W'(1) : cfg_data;
    assign last  = (cnt_q == (n_eff - CFG_W'(1)));

    assign dout_valid = din_valid & cfg_valid;
    assign din_ready  = dout_ready & cfg_valid;
    assign cfg_ready  = din_valid & dout_ready & sub_eot & last;
    assign din_xfer   = din_valid & din_ready;
    assign dout_data  = {last, din_data};

    // Advance on each completed sub-transaction; close the group on the last one.
    always_comb begin
        cnt_d = cnt_q;
        if (din_xfer && sub_eot) begin
            if (last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CFG_W'(1);
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A stalled output must hold its payload and new_eot.
    a_dout_stable: assert property (@(posedge clk) disable iff (rst)
        (dout_valid && !dout_ready) |=> $stable(dout_data));

    // The group size is only ever consumed together with the item that ends the group.
    a_cfg_with_din: assert property (@(posedge clk) disable iff (rst)
        (cfg_valid && cfg_ready) |-> din_ready);

endmodule
